nco_sweep_ctrl: RTL
===================

# nco_sweep_ctrl

Frequency-sweep scheduler for the LO numerically-controlled oscillator. Drives the NCO phase-increment word and clock enable, so the mixer output can be swept across a programmed band without manual retuning. Sits between the control/register side and the `lo_nco` instance in the top level. It steps the increment from a start value to a stop value, holding each point for a programmed dwell time.

## Interface
- `PHASE_W`, 8, width of the phase-increment word (matches NCO `pi` input)
- `DWELL_W`, 16, width of the dwell counter
- `pll_clock`  in  1  sole clock, PLL output
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  single-cycle request to begin a sweep; sampled only in IDLE
- `abort`  in  1  stop the sweep immediately; wins over `start`
- `continuous`  in  1  1 = restart the sweep after the end point instead of finishing
- `f_start`  in  PHASE_W  first phase increment
- `f_stop`  in  PHASE_W  upper bound on the increment (inclusive)
- `f_step`  in  PHASE_W  increment added per point
- `dwell`  in  DWELL_W  each point is held `dwell`+1 cycles
- `phase_inc`  out  PHASE_W  to NCO phase-increment input
- `inc_valid`  out  1  one-cycle pulse whenever `phase_inc` takes a new point
- `nco_en`  out  1  to NCO `clk_en`
- `busy`  out  1  a sweep is in progress
- `done`  out  1  one-cycle pulse at sweep completion

## Operation
- States: IDLE, DWELL, DONE. DONE lasts exactly one cycle, then returns to IDLE.
- Reset value of every output is 0, state is IDLE, and internal registers are 0.
- **IDLE, `start`=1, `abort`=0:**
  - Capture `f_start`, `f_stop`, `f_step`, `dwell` and `continuous` into shadow registers; later input changes are ignored until the next start.
  - `phase_inc`←`f_start`, `inc_valid`←1, `nco_en`←1, `busy`←1.
  - Dwell counter←`dwell`; go to DWELL.
- **DWELL, counter ≠ 0:** decrement the counter.
- **DWELL, counter = 0:** compute `next` = `phase_inc` + `f_step` as a PHASE_W+1-bit unsigned sum.
  - If `f_step` ≠ 0 and `next` ≤ `f_stop`: `phase_inc`←`next[PHASE_W-1:0]`, `inc_valid`←1, counter←`dwell`.
  - Else if `continuous`: `phase_inc`←`f_start`, `inc_valid`←1, counter←`dwell`.
  - Else: go to DONE with `done`←1 and `busy`←0.
- **DONE:**
  - `phase_inc` keeps the last point and `nco_en` stays 1, so the final tone persists.
  - A new `start` is accepted once back in IDLE.
- **`abort`, any state:** next cycle is IDLE with `phase_inc`=0, `nco_en`=0, `busy`=0. No `done` pulse, no `inc_valid`.
- **`start` while busy:** ignored.
- **`start` and `abort` in the same cycle:** abort behaviour applies.
- **`f_start` > `f_stop`:** a single point at `f_start` is held `dwell`+1 cycles, then DONE (non-continuous) or repeat (continuous).
- **`f_step` = 0:** same single-point behaviour as `f_start` > `f_stop`.
- **Overflow:** the PHASE_W+1-bit compare guarantees an overflowing sum is never emitted. `f_stop` is not necessarily hit exactly.
- **`rst_n` low mid-sweep:** all state clears immediately (asynchronous); no `done` pulse.

## Timing
- `start` sampled at edge T: first point visible at T+1 with `inc_valid`=1.
- Each point is held exactly `dwell`+1 cycles; `inc_valid` is high only on the first of those cycles.
- `done` is high for one cycle immediately after the last cycle of the last point; `busy` falls on that same cycle.
- All outputs are registered; there is no combinational input-to-output path.
- Throughput: a new point at most every cycle (`dwell`=0).

## Configuration
- `SWEEP_PINGPONG_EN` defined: triangle sweep.
  - At the upper end (`next` > `f_stop`) direction reverses and the increment descends by `f_step`.
  - The downward sweep stops at the last value ≥ `f_start`, with the compare done at PHASE_W+1 bits and no underflow emitted.
  - Non-continuous: DONE after returning to `f_start`.
  - Continuous: reverse again and repeat.
  - Turnaround points are not repeated.
- Undefined: sawtooth only, exactly as in Operation; the direction register and down-compare logic are not compiled.

## Structure
- Package `nco_sweep_pkg`:
  - state enum (IDLE, DWELL, DONE)
  - `PHASE_W`/`DWELL_W` defaults
  - direction enum (UP, DOWN) under `SWEEP_PINGPONG_EN`
- Sub-module `dwell_timer` (load, decrement, zero flag, asynchronous clear). Everything else is in `nco_sweep_ctrl`.

## Test plan
- Basic sweep: start=3, stop=13, step=5, dwell=2, start at T → `phase_inc` 3 on T+1..T+3, 8 on T+4..T+6, 13 on T+7..T+9; `done` at T+10; `inc_valid` at T+1, T+4, T+7.
- Overflow bound: start=250, stop=255, step=4, dwell=0 → 250, 254, then `done`; 258 is never emitted.
- Continuous mode: start=3, stop=9, step=3, dwell=0, continuous=1 → 3, 6, 9, 3, 6… with no `done`; then `abort` → next cycle `phase_inc`=0, `nco_en`=0, `busy`=0.
- Degenerate inputs:
  - step=0, dwell=4 → single point at `f_start` for 5 cycles, then `done`.
  - start=20, stop=10 → same single-point behaviour.
- Collisions: `start`+`abort` together in IDLE → remains IDLE; `start` while busy → ignored, and the sweep sequence is unchanged.
- `SWEEP_PINGPONG_EN`: start=2, stop=8, step=3, dwell=0, non-continuous → 2, 5, 8, 5, 2, then `done`. `rst_n` low mid-sweep → all outputs 0 immediately.

Source files
------------

// File: rtl/nco_sweep_pkg.sv
// Shared types for the LO NCO sweep scheduler.
// SWEEP_PINGPONG_EN adds the sweep direction type.
package nco_sweep_pkg;

  localparam int PHASE_W_DEF = 8;
  localparam int DWELL_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    DWELL,
    DONE
  } state_t;

`ifdef SWEEP_PINGPONG_EN
  typedef enum logic {
    UP,
    DOWN
  } dir_t;
`endif

endpackage

// File: rtl/nco_sweep_ctrl_dwell_timer.sv
// Per-point hold counter: load, count down to zero, clear.
// Also clears asynchronously on rst_n.
module dwell_timer #(
  parameter int W = 16
) (
  input  logic         pll_clock,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge pll_clock or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Sweeps the NCO phase increment from f_start toward f_stop with a dwell.
// Define SWEEP_PINGPONG_EN for a triangle (up/down) sweep.
module nco_sweep_ctrl
  import nco_sweep_pkg::*;
#(
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic               pll_clock,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic               continuous,
  input  logic [PHASE_W-1:0] f_start,
  input  logic [PHASE_W-1:0] f_stop,
  input  logic [PHASE_W-1:0] f_step,
  input  logic [DWELL_W-1:0] dwell,
  output logic [PHASE_W-1:0] phase_inc,
  output logic               inc_valid,
  output logic               nco_en,
  output logic               busy,
  output logic               done
);

  state_t state, state_n;

  logic [PHASE_W-1:0] start_q, start_n;
  logic [PHASE_W-1:0] stop_q, stop_n;
  logic [PHASE_W-1:0] step_q, step_n;
  logic [DWELL_W-1:0] dwell_q, dwell_n;
  logic               cont_q, cont_n;

  logic [PHASE_W-1:0] phase_n;
  logic               valid_n, nco_en_n, busy_n, done_n;

  logic               t_clr, t_load, t_dec, t_zero;
  logic [DWELL_W-1:0] t_val;

  logic               adv;
  logic [PHASE_W-1:0] adv_val;

  // Sums/diffs carry one extra bit so overflow never aliases into range
  logic [PHASE_W:0] up_sum;
  logic             up_ok;

  assign up_sum = {1'b0, phase_inc} + {1'b0, step_q};
  assign up_ok  = (step_q != '0) && (up_sum <= {1'b0, stop_q});

`ifdef SWEEP_PINGPONG_EN
  dir_t dir, dir_n, dir_sel;
  logic [PHASE_W:0] dn_diff;
  logic             dn_ok;

  assign dn_diff = {1'b0, phase_inc} - {1'b0, step_q};
  assign dn_ok   = (step_q != '0) && !dn_diff[PHASE_W] &&
                   (dn_diff >= {1'b0, start_q});

  always_comb begin
    adv     = 1'b1;
    adv_val = start_q;
    dir_sel = UP;
    if (dir == UP) begin
      if (up_ok) begin
        adv_val = up_sum[PHASE_W-1:0];
      end else if (dn_ok) begin
        adv_val = dn_diff[PHASE_W-1:0];
        dir_sel = DOWN;
      end else begin
        adv = cont_q;
      end
    end else begin
      if (dn_ok) begin
        adv_val = dn_diff[PHASE_W-1:0];
        dir_sel = DOWN;
      end else if (!cont_q) begin
        adv = 1'b0;
      end else if (up_ok) begin
        adv_val = up_sum[PHASE_W-1:0];
      end
    end
  end
`else
  always_comb begin
    adv     = up_ok || cont_q;
    adv_val = up_ok ? up_sum[PHASE_W-1:0] : start_q;
  end
`endif

  dwell_timer #(
    .W(DWELL_W)
  ) u_timer (
    .pll_clock(pll_clock),
    .rst_n    (rst_n),
    .clr      (t_clr),
    .load     (t_load),
    .dec      (t_dec),
    .load_val (t_val),
    .zero     (t_zero)
  );

  always_comb begin
    state_n  = state;
    start_n  = start_q;
    stop_n   = stop_q;
    step_n   = step_q;
    dwell_n  = dwell_q;
    cont_n   = cont_q;
    phase_n  = phase_inc;
    valid_n  = 1'b0;
    nco_en_n = nco_en;
    busy_n   = busy;
    done_n   = 1'b0;
    t_clr    = 1'b0;
    t_load   = 1'b0;
    t_dec    = 1'b0;
    t_val    = dwell_q;
`ifdef SWEEP_PINGPONG_EN
    dir_n    = dir;
`endif
    if (abort) begin
      state_n  = IDLE;
      phase_n  = '0;
      nco_en_n = 1'b0;
      busy_n   = 1'b0;
      t_clr    = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state_n  = DWELL;
            start_n  = f_start;
            stop_n   = f_stop;
            step_n   = f_step;
            dwell_n  = dwell;
            cont_n   = continuous;
            phase_n  = f_start;
            valid_n  = 1'b1;
            nco_en_n = 1'b1;
            busy_n   = 1'b1;
            t_load   = 1'b1;
            t_val    = dwell;
`ifdef SWEEP_PINGPONG_EN
            dir_n    = UP;
`endif
          end
        end
        DWELL: begin
          if (!t_zero) begin
            t_dec = 1'b1;
          end else if (adv) begin
            phase_n = adv_val;
            valid_n = 1'b1;
            t_load  = 1'b1;
`ifdef SWEEP_PINGPONG_EN
            dir_n   = dir_sel;
`endif
          end else begin
            state_n = DONE;
            done_n  = 1'b1;
            busy_n  = 1'b0;
          end
        end
        DONE: state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge pll_clock or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      start_q   <= '0;
      stop_q    <= '0;
      step_q    <= '0;
      dwell_q   <= '0;
      cont_q    <= 1'b0;
      phase_inc <= '0;
      inc_valid <= 1'b0;
      nco_en    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef SWEEP_PINGPONG_EN
      dir       <= UP;
`endif
    end else begin
      state     <= state_n;
      start_q   <= start_n;
      stop_q    <= stop_n;
      step_q    <= step_n;
      dwell_q   <= dwell_n;
      cont_q    <= cont_n;
      phase_inc <= phase_n;
      inc_valid <= valid_n;
      nco_en    <= nco_en_n;
      busy      <= busy_n;
      done      <= done_n;
`ifdef SWEEP_PINGPONG_EN
      dir       <= dir_n;
`endif
    end
  end

endmodule
